// File: rtl/mem_a_skew.sv
// ---------------------------------------------------------------------------
// mem_a_skew
//   Operand-A staging memory for a DIM x DIM systolic matrix unit.
//   Holds DIM rows of signed A data, each loaded as a full row in one cycle.
//   While enabled, every row emits one element per cycle. Row r sits behind
//   r leading zero slots, so the outputs form the skewed wavefront that the
//   array consumes.
//
// Ports
//   clk    : system clock, rising-edge active
//   rst_n  : asynchronous active-low reset; clears all storage and Aout
//   en     : shift enable; advances every row that is not being written
//   WrEn   : load the row selected by Arow with Ain
//   Ain    : full row of data; Ain[0] is emitted first
//   Arow   : row index to load (values >= DIM are ignored)
//   Aout   : registered skewed output, one element per row
// ---------------------------------------------------------------------------
module mem_a_skew #(
  parameter  int BITS_AB = 8,
  parameter  int DIM     = 8,
  localparam int ROWBITS = $clog2(DIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain  [DIM-1:0],
  input  logic        [ROWBITS-1:0] Arow,
  output logic signed [BITS_AB-1:0] Aout [DIM-1:0]
);

  for (genvar r = 0; r < DIM; r++) begin : g_row
    // r skew slots followed by DIM data slots; slot 0 is the head
    localparam int LEN = DIM + r;

    logic signed [BITS_AB-1:0] slot [LEN];
    logic signed [BITS_AB-1:0] aout_q;
    logic                      wr_hit;

    // An out-of-range Arow simply never matches any row
    assign wr_hit = WrEn && (32'(Arow) == 32'(r));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < LEN; k++) slot[k] <= '0;
        aout_q <= '0;
      end else if (wr_hit) begin
        // Clear every slot, then overwrite the data slots; the later
        // non-blocking assignment wins, leaving only the skew slots zeroed.
        // The write takes priority over a simultaneous shift, so aout_q holds.
        for (int unsigned k = 0; k < LEN; k++) slot[k] <= '0;
        for (int unsigned j = 0; j < DIM; j++) slot[j + r] <= Ain[j];
      end else if (en) begin
        aout_q <= slot[0];
        for (int unsigned k = 0; k + 1 < LEN; k++) slot[k] <= slot[k + 1];
        slot[LEN-1] <= '0;
      end
    end

    assign Aout[r] = aout_q;
  end

endmodule

// File: tb/tb_mem_a_skew.sv
// ---------------------------------------------------------------------------
// tb_mem_a_skew
//   Self-checking bench for mem_a_skew (DIM=8, BITS_AB=8). A queue-per-row
//   reference model predicts Aout; a compare process checks every row on
//   every falling edge, and a few literal spot checks pin the model.
// ---------------------------------------------------------------------------
module tb_mem_a_skew;
  localparam int DIM = 8;
  localparam int B   = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                WrEn = 1'b0;
  logic signed [B-1:0] Ain  [DIM-1:0];
  logic        [2:0]   Arow = '0;
  logic signed [B-1:0] Aout [DIM-1:0];

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference model: each row is a queue of pending elements
  logic signed [B-1:0] mq    [DIM][$];
  logic signed [B-1:0] m_out [DIM];

  mem_a_skew #(.BITS_AB(B), .DIM(DIM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .WrEn (WrEn),
    .Ain  (Ain),
    .Arow (Arow),
    .Aout (Aout)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        mq[r].delete();
        m_out[r] = '0;
      end
    end else begin
      for (int r = 0; r < DIM; r++) begin
        if (WrEn && int'(Arow) == r) begin
          mq[r].delete();
          for (int k = 0; k < r; k++) mq[r].push_back('0);
          for (int j = 0; j < DIM; j++) mq[r].push_back(Ain[j]);
        end else if (en) begin
          if (mq[r].size() > 0) m_out[r] = mq[r].pop_front();
          else m_out[r] = '0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int r = 0; r < DIM; r++)
        chk($sformatf("model Aout[%0d]", r), int'(Aout[r]), int'(m_out[r]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inc();
    en = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) Ain[j] = B'(8 * r + j + 1);
      Arow = 3'(r);
      WrEn = 1'b1;
      tick();
    end
    WrEn = 1'b0;
  endtask

  task automatic load_rand();
    en = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) Ain[j] = B'($urandom);
      Arow = 3'(r);
      WrEn = 1'b1;
      tick();
    end
    WrEn = 1'b0;
  endtask

  task automatic drain(input int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < DIM; j++) Ain[j] = '0;
    repeat (3) tick();
    chk_on = 1'b1;
    chk("reset Aout[0]", int'(Aout[0]), 0);
    chk("reset Aout[7]", int'(Aout[7]), 0);
    rst_n = 1'b1;
    drain(3 * DIM - 2);
    chk("post-reset drain Aout[4]", int'(Aout[4]), 0);

    // Full load and drain with spot checks
    load_inc();
    en = 1'b1;
    for (int n = 1; n <= 3 * DIM - 2; n++) begin
      tick();
      if (n == 1) begin
        chk("n1 Aout[0]", int'(Aout[0]), 1);
        chk("n1 Aout[1]", int'(Aout[1]), 0);
      end
      if (n == 8) begin
        chk("n8 Aout[7]", int'(Aout[7]), 57);
        chk("n8 Aout[0]", int'(Aout[0]), 8);
      end
      if (n == 15) begin
        chk("n15 Aout[7]", int'(Aout[7]), 64);
        chk("n15 Aout[6]", int'(Aout[6]), 0);
      end
      if (n == 16) chk("n16 Aout[7]", int'(Aout[7]), 0);
    end
    en = 1'b0;

    // Signed extremes
    en = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) Ain[j] = (j % 2 == 0) ? -8'sd128 : 8'sd127;
      Arow = 3'(r);
      WrEn = 1'b1;
      tick();
    end
    WrEn = 1'b0;
    en = 1'b1;
    tick();
    chk("signed n1 Aout[0]", int'(Aout[0]), -128);
    tick();
    chk("signed n2 Aout[0]", int'(Aout[0]), 127);
    chk("signed n2 Aout[1]", int'(Aout[1]), -128);
    drain(3 * DIM - 4);

    // Hold mid-stream
    load_inc();
    drain(5);
    chk("hold pre Aout[0]", int'(Aout[0]), 5);
    repeat (3) tick();
    chk("hold frozen Aout[0]", int'(Aout[0]), 5);
    chk("hold frozen Aout[4]", int'(Aout[4]), 33);
    en = 1'b1;
    tick();
    chk("hold resume Aout[0]", int'(Aout[0]), 6);
    drain(3 * DIM - 3);

    // Write during shift on row 3
    load_inc();
    drain(4);
    chk("wds pre Aout[3]", int'(Aout[3]), 25);
    for (int j = 0; j < DIM; j++) Ain[j] = B'(100 + j);
    Arow = 3'd3;
    WrEn = 1'b1;
    en = 1'b1;
    tick();
    WrEn = 1'b0;
    chk("wds held Aout[3]", int'(Aout[3]), 25);
    chk("wds shift Aout[0]", int'(Aout[0]), 5);
    tick();
    chk("wds skew Aout[3]", int'(Aout[3]), 0);
    repeat (2) tick();
    chk("wds skew2 Aout[3]", int'(Aout[3]), 0);
    tick();
    chk("wds reload Aout[3]", int'(Aout[3]), 100);
    drain(3 * DIM);

    // Random matrices, loaded then drained
    for (int m = 0; m < 10; m++) begin
      load_rand();
      drain(3 * DIM - 2);
    end

    // Random mixed traffic
    for (int c = 0; c < 300; c++) begin
      en   = 1'($urandom);
      WrEn = ($urandom_range(0, 3) == 0);
      Arow = 3'($urandom);
      for (int j = 0; j < DIM; j++) Ain[j] = B'($urandom);
      tick();
    end
    WrEn = 1'b0;

    // Asynchronous reset mid-stream
    load_inc();
    drain(6);
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst Aout[0]", int'(Aout[0]), 0);
    chk("async rst Aout[5]", int'(Aout[5]), 0);
    tick();
    rst_n = 1'b1;
    drain(3 * DIM - 2);
    chk("after rst drain Aout[7]", int'(Aout[7]), 0);

    tick();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_a_skew.md
Name: mem_a_skew

Overview:
Operand-A staging memory for a DIM x DIM systolic matrix unit. It holds DIM rows of signed A-matrix data, loaded one full row per cycle. Once enabled, it streams the rows out in parallel, one element per row per cycle. Row r is delayed by r cycles, so the emitted sequence forms the skewed, rhombus-shaped wavefront the array consumes.

Parameters:
BITS_AB, 8, width of each signed A element.
DIM, 8, matrix dimension: number of rows, and elements per row.
ROWBITS, $clog2(DIM), width of the row-select port (derived, not overridden).

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous and active-low.
en  input  1  shift enable; each asserted cycle advances every row by one element.
WrEn  input  1  write enable for the row selected by Arow.
Ain  input  DIM x BITS_AB (signed, unpacked [DIM-1:0])  full row of data to store.
Arow  input  ROWBITS  index of the row buffer to load.
Aout  output  DIM x BITS_AB (signed, unpacked [DIM-1:0])  registered skewed output, one element per row.

Behaviour:
- Storage: row buffer r (r = 0..DIM-1) is a shift chain of length DIM+r.
  - Slots 0..r-1 are skew slots.
  - Slots r..r+DIM-1 are data slots.
  - Slot 0 is the head.
- Reset (rst_n=0, asynchronous): every slot of every row = 0, and every Aout[r] = 0. Reset mid-stream discards all data immediately.
- Write (WrEn=1 at a rising edge), applied to row Arow:
  - Skew slots 0..r-1 are cleared to 0.
  - Data slot r+j <= Ain[j] for j = 0..DIM-1, so Ain[0] is emitted first.
  - Other rows are unaffected by the write.
- Shift (en=1 at a rising edge), applied to every row not being written that cycle:
  - Aout[r] <= slot0.
  - Each slot k <= slot k+1.
  - The last slot <= 0 (zero fill).
- Write and en in the same cycle: the write wins for row Arow. That row loads and does not shift, and its Aout[r] holds its value. All other rows shift normally.
- en=0 with no write: all state and Aout hold.
- Latency: after a row is written and no further writes occur, the n-th en cycle (n >= 1) yields:
  - Aout[r] = stored Ain_r[n-1-r] when 0 <= n-1-r < DIM;
  - otherwise Aout[r] = 0.
- Row 0 produces data on en cycles 1..DIM. Row DIM-1 produces data on en cycles DIM..2*DIM-1. From en cycle 2*DIM onward all outputs are 0, which is the drain condition.
- Stream length: a 3*DIM-2 cycle capture window contains the full rhombus plus trailing zeros.
- Arow values are always in range when DIM is a power of two. For other DIM, Arow >= DIM is ignored (no write).
- Data is passed through unchanged: no arithmetic and no sign extension.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> all Aout = 0 immediately, and remain 0 after release with en=1 for 3*DIM-2 cycles.
- Full load and drain (DIM=8): write row r with Ain[j] = 8r+j+1 for r=0..7, then hold en=1 for 22 cycles -> on en cycle n, Aout[r] = 8r+(n-1-r)+1 when 0 <= n-1-r <= 7, else 0.
  - Spot checks: n=1: Aout[0]=1, others 0. n=8: Aout[7]=57, Aout[0]=8. n=15: only Aout[7]=64. n>=16: all 0.
- Signed data: write all rows with -128 and 127 alternating, then enable -> values reappear bit-exact on the skewed schedule.
- Hold: with data loaded, toggle en=0 for 3 cycles mid-stream -> Aout frozen during those cycles, and the sequence resumes with no element lost or duplicated.
- Write during shift: en=1 while WrEn=1 with Arow=3 -> row 3 reloads (skew slots zeroed, Aout[3] held) while rows 0-2 and 4-7 advance one element.
- Random regression: 10 random 8x8 matrices, each loaded then drained -> captured 22x8 output equals the skewed rhombus of the matrix, with zero errors.
